muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
Multi-cycle multiply/divide unit and HI/LO owner, sitting in the E stage beside the ALU. It accepts the decoder's mulCtrl command with rs/rt operands and runs MUL/DIV operations over a fixed number of cycles. It raises a stall request when a later HI/LO consumer reaches E while an operation is still in flight. It commits results to HI/LO and serves mfhi/mflo reads.

Parameters:
MUL_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub (min 1)
DIV_CYCLES, 10, busy cycles for div/divu (min 1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  valid instruction in E (not bubble); qualifies ctrl
ctrl  in  4  mulCtrl code (`mtDisabled, `mtMultiply, `mtMultiplyUnsigned, `mtDivide, `mtDivideUnsigned, `mtMADD, `mtMADDU, `mtMSUB, `mtSetHI, `mtSetLO)
a  in  32  forwarded rs value
b  in  32  forwarded rt value
flush  in  1  E-stage instruction cancelled (exception/ERET) this cycle
readReq  in  1  mfhi/mflo in E this cycle
outSel  in  1  1 = HI, 0 = LO
out  out  32  outSel ? HI : LO, combinational
hi  out  32  HI register
lo  out  32  LO register
busy  out  1  operation in flight
stall  out  1  freeze F/D/E and bubble M

Behaviour:
- Decided: one clock `clk`; `reset` is synchronous and active-high.
- Reset: HI=0, LO=0, busy=0, state IDLE, counter=0. Reset mid-operation abandons the operation; no HI/LO commit.
- issue = start & ~flush & (ctrl != `mtDisabled) & ~busy.
- States: IDLE, RUN.
- IDLE, issue with `mtSetHI/`mtSetLO: HI (resp. LO) <= a at that edge. Stay IDLE, busy stays 0.
- IDLE, issue with a MUL-class code: latch a, b, ctrl. Counter <= MUL_CYCLES-1. Go to RUN.
- IDLE, issue with a DIV-class code: same as MUL-class, but counter <= DIV_CYCLES-1.
- RUN: busy=1. Counter decrements each cycle. When counter==0: commit HI/LO at that edge and return to IDLE.
- Latency: busy is high for exactly N cycles, starting the cycle after issue. The new HI/LO is visible on hi/lo/out in the first cycle after busy falls.
- Back-to-back: an issue may occur in the cycle busy first reads 0.
- Arithmetic, on latched operands:
  - mult: {HI,LO} = signed a*b. multu: unsigned.
  - madd: {HI,LO} += signed a*b. maddu: unsigned accumulate. msub: {HI,LO} -= signed a*b. All 64-bit, wrap modulo 2^64. The accumulator is {HI,LO} as of commit time.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient and remainder.
  - Divide by zero (b==0): HI and LO unchanged; busy still runs DIV_CYCLES.
- Implementation may compute iteratively or at issue; only the commit timing above is observable.
- stall = busy & (readReq | (start & ctrl != `mtDisabled)), combinational. A command or read arriving while busy is ignored and re-presented by the held pipeline.
- flush with start: no issue, no state change. flush during RUN has no effect: the in-flight op commits.
- start with ctrl=`mtDisabled: no effect.
- readReq while not busy: no stall; out gives current HI/LO.
- out/hi/lo hold their old values throughout RUN.

Test Plan:
- mult a=0xFFFFFFFD (-3), b=5 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1. multu same operands -> HI=0x00000004, LO=0xFFFFFFF1.
- div a=7, b=0xFFFFFFFE -> after 10 busy cycles LO=0xFFFFFFFD, HI=0x00000001. div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. divu by 0 -> HI/LO unchanged.
- mthi a=0x12345678, mtlo a=0x9, then madd a=2, b=3 -> HI=0x12345678, LO=0xF; then msub a=1, b=0x10 -> LO=0xFFFFFFFF, HI=0x12345677.
- mult issued, readReq=1 with outSel=1 on the next cycle -> stall=1 for the remaining 5 busy cycles; stall=0 the cycle busy falls, and out equals the new HI.
- start=1, flush=1, ctrl=`mtDivide -> busy stays 0, HI/LO unchanged. A second mult presented while busy -> stall=1, no reload of operands.
- reset asserted in the 4th cycle of a div -> next cycle busy=0, HI=LO=0, stall=0; a subsequent mult runs normally.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide unit that owns HI/LO in the E stage.
// Operands are latched at issue, and the result is committed to HI/LO when the busy countdown expires.
module muldiv_sequencer #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  ctrl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        readReq,
    input  logic        outSel,
    output logic [31:0] out,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall
);
    localparam logic [3:0] MT_DISABLED = 4'd0;
    localparam logic [3:0] MT_MULT     = 4'd1;
    localparam logic [3:0] MT_MULTU    = 4'd2;
    localparam logic [3:0] MT_DIV      = 4'd3;
    localparam logic [3:0] MT_DIVU     = 4'd4;
    localparam logic [3:0] MT_MADD     = 4'd5;
    localparam logic [3:0] MT_MADDU    = 4'd6;
    localparam logic [3:0] MT_MSUB     = 4'd7;
    localparam logic [3:0] MT_SETHI    = 4'd8;
    localparam logic [3:0] MT_SETLO    = 4'd9;

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state, state_n;
    logic [CW-1:0]  count, count_n;
    logic [31:0]    op_a, op_a_n, op_b, op_b_n;
    logic [3:0]     op_ctrl, op_ctrl_n;
    logic [31:0]    hi_n, lo_n;
    logic [31:0]    commit_hi, commit_lo;

    logic issue, is_mul, is_div;
    logic [63:0] prod_s, prod_u, acc;
    logic        a_neg, b_neg;
    logic [31:0] mag_a, mag_b, q_u, r_u, q, r;

    // Handshake: start qualifies ctrl/a/b; the command is accepted only when
    // busy is low. While busy, stall holds the pipeline so the same command
    // (or mfhi/mflo read) is re-presented until it can be served.
    assign busy  = (state == RUN);
    assign stall = busy & (readReq | (start & (ctrl != MT_DISABLED)));
    assign out   = outSel ? hi : lo;

    assign issue  = start & ~flush & (ctrl != MT_DISABLED) & ~busy;
    assign is_mul = (ctrl == MT_MULT) || (ctrl == MT_MULTU) || (ctrl == MT_MADD) ||
                    (ctrl == MT_MADDU) || (ctrl == MT_MSUB);
    assign is_div = (ctrl == MT_DIV) || (ctrl == MT_DIVU);

    // A signed product is the low 64 bits of the product of the sign-extended operands.
    assign prod_s = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
    assign prod_u = {32'd0, op_a} * {32'd0, op_b};
    assign acc    = {hi, lo};

    // Signed division works on magnitudes, so 0x80000000 / -1 cannot overflow.
    assign a_neg = (op_ctrl == MT_DIV) & op_a[31];
    assign b_neg = (op_ctrl == MT_DIV) & op_b[31];
    assign mag_a = a_neg ? (~op_a + 32'd1) : op_a;
    assign mag_b = b_neg ? (~op_b + 32'd1) : op_b;
    assign q_u   = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
    assign r_u   = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
    assign q     = (a_neg ^ b_neg) ? (~q_u + 32'd1) : q_u;
    assign r     = a_neg ? (~r_u + 32'd1) : r_u;

    always_comb begin
        commit_hi = hi;
        commit_lo = lo;
        case (op_ctrl)
            MT_MULT:  {commit_hi, commit_lo} = prod_s;
            MT_MULTU: {commit_hi, commit_lo} = prod_u;
            MT_MADD:  {commit_hi, commit_lo} = acc + prod_s;
            MT_MADDU: {commit_hi, commit_lo} = acc + prod_u;
            MT_MSUB:  {commit_hi, commit_lo} = acc - prod_s;
            MT_DIV, MT_DIVU: begin
                if (op_b != 32'd0) begin
                    commit_lo = q;
                    commit_hi = r;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n   = state;
        count_n   = count;
        op_a_n    = op_a;
        op_b_n    = op_b;
        op_ctrl_n = op_ctrl;
        hi_n      = hi;
        lo_n      = lo;
        case (state)
            IDLE: begin
                if (issue) begin
                    if (ctrl == MT_SETHI) begin
                        hi_n = a;
                    end else if (ctrl == MT_SETLO) begin
                        lo_n = a;
                    end else if (is_mul || is_div) begin
                        op_a_n    = a;
                        op_b_n    = b;
                        op_ctrl_n = ctrl;
                        count_n   = is_div ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
                        state_n   = RUN;
                    end
                end
            end
            RUN: begin
                if (count == '0) begin
                    hi_n    = commit_hi;
                    lo_n    = commit_lo;
                    state_n = IDLE;
                end else begin
                    count_n = count - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_ctrl <= MT_DISABLED;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            op_a    <= op_a_n;
            op_b    <= op_b_n;
            op_ctrl <= op_ctrl_n;
            hi      <= hi_n;
            lo      <= lo_n;
        end
    end
endmodule
